// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: the FSM state
// encoding, the NOP instruction loaded by flushed registers, and the bundle
// of per-stage enable/flush strobes with the handful of patterns it takes.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_LU  = 2'd1,
        ST_MW  = 2'd2,
        ST_HLT = 2'd3
    } state_e;

    // Instruction word a flushed IF/ID or ID/EX register loads.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    // Everything frozen: reset and data-memory wait.
    localparam ctrl_t CTRL_OFF = '{default: 1'b0};

    // Normal flow: every register advances.
    localparam ctrl_t CTRL_RUN = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                   exmem_en: 1'b1, memwb_en: 1'b1,
                                   ifid_flush: 1'b0, idex_flush: 1'b0};

    // Front end held, bubble into ID/EX, back end drains (load-use and halt).
    localparam ctrl_t CTRL_HOLD = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1,
                                    exmem_en: 1'b1, memwb_en: 1'b1,
                                    ifid_flush: 1'b0, idex_flush: 1'b1};

    // Taken branch: fetch the target, squash the two wrong-path instructions.
    localparam ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                      exmem_en: 1'b1, memwb_en: 1'b1,
                                      ifid_flush: 1'b1, idex_flush: 1'b1};

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/event inputs and per-stage control outputs of the stall sequencer.
// The master side is the pipeline datapath; the slave side is the sequencer.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             hz_load_use;
    logic             br_taken;
    logic             mem_busy;
    logic             halt_req;
    logic             resume;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output hz_load_use, br_taken, mem_busy, halt_req, resume,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  hz_load_use, br_taken, mem_busy, halt_req, resume,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter for performance monitoring: counts qualifying
// cycles, sticks at all-ones, cleared only by reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Count up on each qualifying cycle until the ceiling is reached.
    // NOTE: state registers use non-blocking (<=) so every flop samples its
    // inputs from before the edge, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage 16-bit pipeline. Merges
// load-use, taken-branch, data-memory-busy and halt events into per-stage
// register enables and bubble strobes, and counts stall cycles and accepted
// branch flushes. Event priority: mem_busy > halt_req > br_taken > load-use.
module pipe_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int LU_STALL_CYC = 1,  // front-end freeze length per load-use, 1..7
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_stall_ctrl_if.slave    bus
);
    localparam logic [2:0] LU_RELOAD = 3'(LU_STALL_CYC - 1);

    state_e     state;
    state_e     ret_state;   // RUN or LU_STALL to resume after a memory wait
    logic [2:0] lu_cnt;      // load-use stall cycles still to go after this one

    state_e     eff_state;
    state_e     state_nx;
    state_e     ret_nx;
    logic [2:0] lu_nx;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;
    logic       br_accept;
    logic       stall_inc;

    // Decode this cycle's strobes and next state from state and event inputs.
    // NOTE: every signal gets a default at the top of the always_comb, so no
    // path through the if/else chain can leave one unassigned and infer a latch.
    always_comb begin
        ctrl      = CTRL_RUN;
        state_nx  = ST_RUN;
        ret_nx    = ret_state;
        lu_nx     = lu_cnt;
        br_accept = 1'b0;
        // The cycle memory becomes ready behaves exactly like the state it
        // interrupted, so a load-use stall resumes without losing a cycle.
        eff_state = (state == ST_MW) ? ret_state : state;

        if (state == ST_HLT) begin
            ctrl     = CTRL_HOLD;
            state_nx = bus.resume ? ST_RUN : ST_HLT;
        end else if (bus.mem_busy) begin
            ctrl     = CTRL_OFF;
            state_nx = ST_MW;
            ret_nx   = eff_state;
        end else if (bus.halt_req) begin
            // Stop fetching beyond HLT right away; the back end keeps draining.
            ctrl     = CTRL_HOLD;
            state_nx = ST_HLT;
            lu_nx    = '0;
        end else if (bus.br_taken) begin
            // The instruction in ID is wrong-path, so any load-use stall is moot.
            ctrl      = CTRL_BRANCH;
            state_nx  = ST_RUN;
            lu_nx     = '0;
            br_accept = 1'b1;
        end else if (eff_state == ST_LU) begin
            ctrl     = CTRL_HOLD;
            lu_nx    = lu_cnt - 1'b1;
            state_nx = (lu_cnt == 3'd1) ? ST_RUN : ST_LU;
        end else if (bus.hz_load_use) begin
            ctrl = CTRL_HOLD;
            if (LU_STALL_CYC > 1) begin
                lu_nx    = LU_RELOAD;
                state_nx = ST_LU;
            end
        end
    end

    // Sequencer state: async reset back to RUN with no pending stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            ret_state <= ST_RUN;
            lu_cnt    <= '0;
        end else begin
            state     <= state_nx;
            ret_state <= ret_nx;
            lu_cnt    <= lu_nx;
        end
    end

    // Strobes are Mealy outputs; reset forces them all low immediately.
    assign ctrl_out = rst_n ? ctrl : CTRL_OFF;

    assign bus.pc_en      = ctrl_out.pc_en;
    assign bus.ifid_en    = ctrl_out.ifid_en;
    assign bus.idex_en    = ctrl_out.idex_en;
    assign bus.exmem_en   = ctrl_out.exmem_en;
    assign bus.memwb_en   = ctrl_out.memwb_en;
    assign bus.ifid_flush = ctrl_out.ifid_flush;
    assign bus.idex_flush = ctrl_out.idex_flush;
    assign bus.halted     = (state == ST_HLT);

    // A halted core is idle rather than stalled, so it is not counted.
    assign stall_inc = !ctrl_out.pc_en && (state != ST_HLT);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (bus.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_accept),
        .count (bus.flush_cnt)
    );
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl. Three instances (LU_STALL_CYC/CNT_W
// of 1/16, 3/16 and 2/4) see identical stimulus. A reference model tracks
// only "halted" and "forced stall cycles remaining" and pushes the expected
// strobes/counters per cycle; a negedge monitor pops and compares.
module tb_pipe_stall_ctrl;

    localparam int N = 3;

    // Flag order: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, halted}
    localparam logic [7:0] F_OFF  = 8'b0000_0000;
    localparam logic [7:0] F_RUN  = 8'b1111_1000;
    localparam logic [7:0] F_HOLD = 8'b0011_1010;
    localparam logic [7:0] F_BR   = 8'b1111_1110;

    typedef struct {
        logic [7:0] flags;
        int         stall;
        int         flush;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb [N][$];

    int   m_cyc  [N] = '{1, 3, 2};
    int   m_max  [N] = '{65535, 65535, 15};
    bit   m_halted [N];
    int   m_lu     [N];
    int   m_stall  [N];
    int   m_flush  [N];

    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.CNT_W(16)) bus0 ();
    pipe_stall_ctrl_if #(.CNT_W(16)) bus1 ();
    pipe_stall_ctrl_if #(.CNT_W(4))  bus2 ();

    pipe_stall_ctrl #(.LU_STALL_CYC(1), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    pipe_stall_ctrl #(.LU_STALL_CYC(3), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    pipe_stall_ctrl #(.LU_STALL_CYC(2), .CNT_W(4))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    logic [7:0]  act_flags [N];
    logic [31:0] act_stall [N];
    logic [31:0] act_flush [N];

    assign act_flags[0] = {bus0.pc_en, bus0.ifid_en, bus0.idex_en, bus0.exmem_en,
                           bus0.memwb_en, bus0.ifid_flush, bus0.idex_flush, bus0.halted};
    assign act_flags[1] = {bus1.pc_en, bus1.ifid_en, bus1.idex_en, bus1.exmem_en,
                           bus1.memwb_en, bus1.ifid_flush, bus1.idex_flush, bus1.halted};
    assign act_flags[2] = {bus2.pc_en, bus2.ifid_en, bus2.idex_en, bus2.exmem_en,
                           bus2.memwb_en, bus2.ifid_flush, bus2.idex_flush, bus2.halted};
    assign act_stall[0] = {16'd0, bus0.stall_cnt};
    assign act_stall[1] = {16'd0, bus1.stall_cnt};
    assign act_stall[2] = {28'd0, bus2.stall_cnt};
    assign act_flush[0] = {16'd0, bus0.flush_cnt};
    assign act_flush[1] = {16'd0, bus1.flush_cnt};
    assign act_flush[2] = {28'd0, bus2.flush_cnt};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v, input int max);
        return (v < max) ? v + 1 : max;
    endfunction

    // Reference model: one call per clock cycle per instance.
    task automatic model_step(input int i, input logic rst, input logic hz, input logic br,
                              input logic mb, input logic hr, input logic rs, output exp_t e);
        if (!rst) begin
            m_halted[i] = 1'b0;
            m_lu[i]     = 0;
            m_stall[i]  = 0;
            m_flush[i]  = 0;
            e = '{F_OFF, 0, 0};
            return;
        end
        e.stall = m_stall[i];
        e.flush = m_flush[i];
        if (m_halted[i]) begin
            e.flags = F_HOLD | 8'h01;
            if (rs) m_halted[i] = 1'b0;
        end else begin
            if (mb) begin
                e.flags = F_OFF;
            end else if (hr) begin
                e.flags     = F_HOLD;
                m_halted[i] = 1'b1;
                m_lu[i]     = 0;
            end else if (br) begin
                e.flags    = F_BR;
                m_lu[i]    = 0;
                m_flush[i] = sat_inc(m_flush[i], m_max[i]);
            end else if (m_lu[i] > 0 || hz) begin
                e.flags = F_HOLD;
                m_lu[i] = (m_lu[i] > 0) ? m_lu[i] - 1 : m_cyc[i] - 1;
            end else begin
                e.flags = F_RUN;
            end
            if (!e.flags[7]) m_stall[i] = sat_inc(m_stall[i], m_max[i]);
        end
    endtask

    // Apply one cycle of stimulus just after the edge and queue expectations.
    task automatic cycle(input logic rst, input logic hz, input logic br,
                         input logic mb, input logic hr, input logic rs);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst;
        bus0.hz_load_use = hz; bus0.br_taken = br; bus0.mem_busy = mb;
        bus0.halt_req = hr;    bus0.resume = rs;
        bus1.hz_load_use = hz; bus1.br_taken = br; bus1.mem_busy = mb;
        bus1.halt_req = hr;    bus1.resume = rs;
        bus2.hz_load_use = hz; bus2.br_taken = br; bus2.mem_busy = mb;
        bus2.halt_req = hr;    bus2.resume = rs;
        for (int i = 0; i < N; i++) begin
            model_step(i, rst, hz, br, mb, hr, rs, e);
            sb[i].push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare each instance's outputs against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (sb[i].size() > 0) begin
                e = sb[i].pop_front();
                check($sformatf("flags%0d", i), {24'd0, act_flags[i]}, {24'd0, e.flags});
                check($sformatf("stall_cnt%0d", i), act_stall[i], e.stall);
                check($sformatf("flush_cnt%0d", i), act_flush[i], e.flush);
            end
        end
    end

    initial begin
        bus0.hz_load_use = 0; bus0.br_taken = 0; bus0.mem_busy = 0; bus0.halt_req = 0; bus0.resume = 0;
        bus1.hz_load_use = 0; bus1.br_taken = 0; bus1.mem_busy = 0; bus1.halt_req = 0; bus1.resume = 0;
        bus2.hz_load_use = 0; bus2.br_taken = 0; bus2.mem_busy = 0; bus2.halt_req = 0; bus2.resume = 0;
        do_reset();
        do_reset();

        // T1: single load-use pulse; each instance stalls LU_STALL_CYC cycles.
        cycle(1, 1, 0, 0, 0, 0);
        idle(4);
        check("t1_stall_c1", act_stall[0], 1);
        check("t1_stall_c3", act_stall[1], 3);
        check("t1_stall_c2", act_stall[2], 2);

        // T2: load-use, then a 4-cycle memory wait in the middle of the stall.
        do_reset();
        cycle(1, 1, 0, 0, 0, 0);
        idle(1);
        repeat (4) cycle(1, 0, 0, 1, 0, 0);
        idle(3);
        check("t2_stall_c3", act_stall[1], 7);

        // T3: branch and load-use together: branch wins, no stall.
        do_reset();
        cycle(1, 1, 1, 0, 0, 0);
        idle(2);
        check("t3_flush", act_flush[0], 1);
        check("t3_stall", act_stall[0], 0);

        // T4: halt, ten halted cycles with ignored events, then resume.
        do_reset();
        cycle(1, 0, 0, 0, 1, 0);
        for (int k = 0; k < 10; k++) cycle(1, k[0], k[1], k[2], 0, 0);
        cycle(1, 0, 0, 0, 0, 1);
        idle(2);
        check("t4_halted", {31'd0, bus0.halted}, 0);
        check("t4_flush_ignored", act_flush[0], 0);

        // T5: 20 back-to-back load-use cycles saturate the 4-bit counter.
        do_reset();
        repeat (20) cycle(1, 1, 0, 0, 0, 0);
        idle(1);
        check("t5_sat_w4", act_stall[2], 15);
        check("t5_stall_w16", act_stall[0], 20);

        // T6: reset asserted between edges in the middle of a load-use stall.
        do_reset();
        cycle(1, 1, 0, 0, 0, 0);
        idle(1);
        do_reset();
        #1;
        check("t6_stall_cleared", act_stall[1], 0);
        check("t6_exmem_en_low", {31'd0, bus1.exmem_en}, 0);
        idle(3);

        // Randomized traffic, including occasional reset pulses.
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(0, 149) != 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 4) == 0));
        end
        idle(2);

        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) check($sformatf("sb_drained%0d", i), sb[i].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
